// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: datapath widths and operation codes.
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: computes the result and zero flag from already-selected operands.
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] shift_src,
  input  logic [4:0]        sa,
  input  logic [3:0]        alu_control,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Operation decode; unused codes 1100-1111 fall through to a zero result.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_AND:  result = a & b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL:  result = shift_src << sa;
      ALU_SRL:  result = shift_src >> sa;
      ALU_SRA:  result = $unsigned($signed(shift_src) >>> sa);
      ALU_LUI:  result = b << 16;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec.sv
// Execute stage: operand muxes, ALU, destination mux, branch adder, and the EX/MEM output registers.
module alu_exec
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     rs,
  input  logic [DATA_W-1:0]     rt,
  input  logic [4:0]            shamt,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     imm,
  input  logic [DATA_W-1:0]     pc,
  input  logic [3:0]            alu_control,
  input  logic                  alu_source,
  input  logic                  alu_source_shift,
  input  logic                  reg_dst,
  output logic                  zero,
  output logic [DATA_W-1:0]     alu_out,
  output logic [DATA_W-1:0]     write_data,
  output logic [REG_ADDR_W-1:0] write_reg_addr,
  output logic [DATA_W-1:0]     pc_branch
);

  logic [DATA_W-1:0]     operand_b;
  logic [4:0]            shift_amount;
  logic [DATA_W-1:0]     result;
  logic                  result_zero;
  logic [REG_ADDR_W-1:0] dest_addr;
  logic [DATA_W-1:0]     branch_target;

  // Shifts always act on rt; only the amount source is selectable.
  assign operand_b     = alu_source ? imm : rt;
  assign shift_amount  = alu_source_shift ? shamt : rs[4:0];
  assign dest_addr     = reg_dst ? rd_addr : rt_addr;
  assign branch_target = pc + (imm << 2);

  alu_core u_core (
    .a           (rs),
    .b           (operand_b),
    .shift_src   (rt),
    .sa          (shift_amount),
    .alu_control (alu_control),
    .result      (result),
    .zero        (result_zero)
  );

  // EX/MEM boundary: load every cycle, reset discards whatever is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero           <= 1'b0;
      alu_out        <= '0;
      write_data     <= '0;
      write_reg_addr <= '0;
      pc_branch      <= '0;
    end else begin
      zero           <= result_zero;
      alu_out        <= result;
      write_data     <= rt;
      write_reg_addr <= dest_addr;
      pc_branch      <= branch_target;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_alu_exec;

  typedef struct packed {
    logic        zero;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  write_reg_addr;
    logic [31:0] pc_branch;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rs = '0, rt = '0, imm = '0, pc = '0;
  logic [4:0]  shamt = '0, rt_addr = '0, rd_addr = '0;
  logic [3:0]  alu_control = '0;
  logic        alu_source = 1'b0, alu_source_shift = 1'b0, reg_dst = 1'b0;
  logic        zero;
  logic [31:0] alu_out, write_data, pc_branch;
  logic [4:0]  write_reg_addr;

  exp_t  expQ[$];
  string nameQ[$];
  exp_t  lastExp;
  bit    havePrev = 1'b0;
  bit    armed = 1'b0;
  int    compared = 0;
  int    mismatched = 0;

  alu_exec dut (
    .clk              (clk),
    .reset            (reset),
    .rs               (rs),
    .rt               (rt),
    .shamt            (shamt),
    .rt_addr          (rt_addr),
    .rd_addr          (rd_addr),
    .imm              (imm),
    .pc               (pc),
    .alu_control      (alu_control),
    .alu_source       (alu_source),
    .alu_source_shift (alu_source_shift),
    .reg_dst          (reg_dst),
    .zero             (zero),
    .alu_out          (alu_out),
    .write_data       (write_data),
    .write_reg_addr   (write_reg_addr),
    .pc_branch        (pc_branch)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // One comparison of every registered output against an expected record.
  task automatic checkOutput(input string name, input exp_t e);
    compared++;
    if (zero !== e.zero || alu_out !== e.alu_out || write_data !== e.write_data ||
        write_reg_addr !== e.write_reg_addr || pc_branch !== e.pc_branch) begin
      mismatched++;
      $display("[TB] FAIL %s: got zero=%0b alu_out=%h write_data=%h wra=%h pc_branch=%h; want zero=%0b alu_out=%h write_data=%h wra=%h pc_branch=%h",
               name, zero, alu_out, write_data, write_reg_addr, pc_branch,
               e.zero, e.alu_out, e.write_data, e.write_reg_addr, e.pc_branch);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, and confirm
  // the new inputs have not disturbed the previously latched outputs.
  task automatic applyStimulus(
    input string name, input bit rst,
    input logic [31:0] i_rs, input logic [31:0] i_rt, input logic [4:0] i_shamt,
    input logic [4:0] i_rt_addr, input logic [4:0] i_rd_addr,
    input logic [31:0] i_imm, input logic [31:0] i_pc, input logic [3:0] i_ctl,
    input bit i_src, input bit i_srcsh, input bit i_regdst,
    input logic [31:0] e_alu, input bit e_zero, input logic [31:0] e_wd,
    input logic [4:0] e_wra, input logic [31:0] e_pcb);
    exp_t e;
    @(negedge clk);
    reset = rst; rs = i_rs; rt = i_rt; shamt = i_shamt;
    rt_addr = i_rt_addr; rd_addr = i_rd_addr; imm = i_imm; pc = i_pc;
    alu_control = i_ctl; alu_source = i_src; alu_source_shift = i_srcsh; reg_dst = i_regdst;
    e.zero = e_zero; e.alu_out = e_alu; e.write_data = e_wd;
    e.write_reg_addr = e_wra; e.pc_branch = e_pcb;
    expQ.push_back(e);
    nameQ.push_back(name);
    armed = 1'b1;
    #1;
    if (havePrev) checkOutput({"hold_before_", name}, lastExp);
    lastExp  = e;
    havePrev = 1'b1;
  endtask

  // Monitor: every rising edge while armed delivers exactly one result.
  always @(posedge clk) begin
    if (armed) begin
      #1;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_empty: got an output with no expectation, want a queued entry");
      end else begin
        checkOutput(nameQ.pop_front(), expQ.pop_front());
      end
    end
  end

  initial begin
    //              name        rst rs            rt            sh  rta    rda    imm           pc    ctl     src srcsh rdst  alu           z  wd            wra    pcb
    applyStimulus("reset_add",  1, 32'd10,       32'd20,       5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0001, 1, 0, 0, 32'd0,        0, 32'd0,        5'h00, 32'd0);
    applyStimulus("addi",       0, 32'd10,       32'd20,       5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0001, 1, 0, 0, 32'd30,       0, 32'd20,       5'h0C, 32'd180);
    applyStimulus("sub_bne",    0, 32'd10,       32'd20,       5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0010, 0, 0, 1, 32'hFFFFFFF6, 0, 32'd20,       5'h09, 32'd180);
    applyStimulus("sub_equal",  0, 32'd20,       32'd20,       5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0010, 0, 0, 1, 32'd0,        1, 32'd20,       5'h09, 32'd180);
    applyStimulus("sll",        0, 32'd10,       32'd20,       5'd2, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b1000, 0, 1, 1, 32'd80,       0, 32'd20,       5'h09, 32'd180);
    applyStimulus("srav",       0, 32'd1,        32'd20,       5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b1010, 0, 0, 1, 32'd10,       0, 32'd20,       5'h09, 32'd180);
    applyStimulus("srav_neg",   0, 32'd4,        32'h80000000, 5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b1010, 0, 0, 1, 32'hF8000000, 0, 32'h80000000, 5'h09, 32'd180);
    applyStimulus("srl",        0, 32'd0,        32'h80000000, 5'd4, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b1001, 0, 1, 1, 32'h08000000, 0, 32'h80000000, 5'h09, 32'd180);
    applyStimulus("slt",        0, 32'd1,        32'd20,       5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0111, 0, 0, 1, 32'd1,        0, 32'd20,       5'h09, 32'd180);
    applyStimulus("slt_neg",    0, 32'hFFFFFFFF, 32'd1,        5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0111, 0, 0, 1, 32'd1,        0, 32'd1,        5'h09, 32'd180);
    applyStimulus("sltu_big",   0, 32'hFFFFFFFF, 32'd1,        5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0110, 0, 0, 1, 32'd0,        1, 32'd1,        5'h09, 32'd180);
    applyStimulus("and",        0, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0000, 0, 0, 0, 32'h0000F000, 0, 32'h0000FF00, 5'h0C, 32'd180);
    applyStimulus("or",         0, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0011, 0, 0, 0, 32'h0000FFF0, 0, 32'h0000FF00, 5'h0C, 32'd180);
    applyStimulus("xor",        0, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0100, 0, 0, 0, 32'h00000FF0, 0, 32'h0000FF00, 5'h0C, 32'd180);
    applyStimulus("nor",        0, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0101, 0, 0, 0, 32'hFFFF000F, 0, 32'h0000FF00, 5'h0C, 32'd180);
    applyStimulus("lui",        0, 32'd0,        32'd7,        5'd0, 5'h0C, 5'h09, 32'h00001234, 32'd100, 4'b1011, 1, 0, 0, 32'h12340000, 0, 32'd7,        5'h0C, 32'd18740);
    applyStimulus("unused_op",  0, 32'd5,        32'd7,        5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b1100, 0, 0, 0, 32'd0,        1, 32'd7,        5'h0C, 32'd180);
    applyStimulus("addi_neg",   0, 32'd10,       32'd3,        5'd0, 5'h0C, 5'h09, 32'hFFFFFFFE, 32'd100, 4'b0001, 1, 0, 0, 32'd8,        0, 32'd3,        5'h0C, 32'd92);
    applyStimulus("add_wrap",   0, 32'hFFFFFFFF, 32'd1,        5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0001, 0, 0, 0, 32'd0,        1, 32'd1,        5'h0C, 32'd180);
    applyStimulus("reset_mid",  1, 32'd10,       32'd20,       5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0001, 1, 0, 0, 32'd0,        0, 32'd0,        5'h00, 32'd0);
    applyStimulus("add_after",  0, 32'd10,       32'd20,       5'd0, 5'h0C, 5'h09, 32'd20,       32'd100, 4'b0001, 1, 0, 0, 32'd30,       0, 32'd20,       5'h0C, 32'd180);
    // Stop issuing, let the monitor drain the last result.
    @(negedge clk);
    armed = 1'b0;
    #1;
    checkOutput("hold_final", lastExp);
    repeat (2) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU of the 5-stage MIPS pipelined CPU.
- Selects operands (register or immediate, shamt or register shift amount) and computes the ALU result, zero flag and branch target.
- Selects the destination register address and forwards rt as store data.
- All outputs are registered once, forming the EX/MEM boundary for these signals.

Parameters:
- none (datapath fixed at 32 bits, register address 5 bits)

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  synchronous, active-high; clears all outputs
- rs  in  32  register operand 1
- rt  in  32  register operand 2; also store data
- shamt  in  5  instruction shift-amount field
- rt_addr  in  5  rt register number
- rd_addr  in  5  rd register number
- imm  in  32  sign-extended immediate
- pc  in  32  PC+4 of the instruction
- alu_control  in  4  operation select
- alu_source  in  1  1: operand B = imm; 0: operand B = rt
- alu_source_shift  in  1  1: shift amount = shamt; 0: shift amount = rs[4:0]
- reg_dst  in  1  1: destination = rd_addr; 0: destination = rt_addr
- zero  out  1  registered (alu_out == 0)
- alu_out  out  32  registered ALU result
- write_data  out  32  registered rt (memory store data)
- write_reg_addr  out  5  registered destination register number
- pc_branch  out  32  registered branch target

Behaviour:
- Operands: A = rs; B = alu_source ? imm : rt; shift amount sa = alu_source_shift ? shamt : rs[4:0]. Shifts always operate on rt.
- alu_control encoding:
  - 0000 AND (A&B)
  - 0001 ADD (A+B)
  - 0010 SUB (A-B)
  - 0011 OR (A|B)
  - 0100 XOR (A^B)
  - 0101 NOR (~(A|B))
  - 0110 SLTU (unsigned A<B ? 1 : 0)
  - 0111 SLT (signed A<B ? 1 : 0)
  - 1000 SLL (rt<<sa)
  - 1001 SRL (rt>>sa, logical)
  - 1010 SRA (rt>>>sa, arithmetic)
  - 1011 LUI (B<<16)
  - 1100–1111: result 0
- Arithmetic: ADD/SUB are 32-bit modulo; overflow is ignored, with no trap and no flag.
- zero = 1 exactly when the 32-bit result is 0. Branches (beq/bne) use SUB and test zero.
- write_data = rt, regardless of alu_source.
- write_reg_addr = reg_dst ? rd_addr : rt_addr.
- pc_branch = pc + (imm << 2), 32-bit modulo.
- Timing: all computation is combinational from the inputs. Every output is captured on the rising clk edge, giving latency 1 cycle; results change only at clock edges.
- Reset: when reset=1 at a rising edge, zero=0, alu_out=0, write_data=0, write_reg_addr=0, pc_branch=0. Reset dominates and discards the in-flight computation. Outputs resume on the first edge with reset=0.
- There is no stall or enable: registers load every non-reset cycle.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit alu_control localparams (ALU_AND … ALU_LUI)
  - DATA_W=32 and REG_ADDR_W=5 constants
- Optional sub-module alu_core: purely combinational operand-to-result/zero logic. alu_exec wraps it with the operand muxes, destination mux, branch adder and output registers.

Test Plan:
- ADDI: rs=10, rt=20, imm=20, pc=100, alu_control=0001, alu_source=1, reg_dst=0, rt_addr=0x0C, rd_addr=0x09 -> after one edge: alu_out=30, zero=0, write_data=20, write_reg_addr=0x0C, pc_branch=180.
- SUB/BNE: same inputs with alu_source=0, alu_control=0010, reg_dst=1 -> alu_out=0xFFFFFFF6, zero=0, write_reg_addr=0x09. With rs=rt=20 -> alu_out=0, zero=1.
- SLL: rt=20, shamt=2, alu_source_shift=1, alu_control=1000 -> alu_out=80.
- SRAV: rs=1, shamt=0, alu_source_shift=0, alu_control=1010, rt=20 -> alu_out=10. With rt=0x80000000, rs=4 -> alu_out=0xF8000000.
- SLT/SLTU: rs=1, rt=20, alu_source=0, alu_control=0111 -> alu_out=1. With rs=0xFFFFFFFF, rt=1: SLT -> 1; SLTU (0110) -> 0.
- Reset/latency: assert reset while ADD inputs are applied -> all outputs 0 at that edge. Deassert -> correct ADD result appears exactly one edge later. Input changes between edges must not alter the outputs.
